// File: rtl/memdatos_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
package memdatos_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte-lane write strobes for an access of the given size starting at lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << lane;
      SZ_HALF: mask = 4'b0011 << lane;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/memdatos_lane_align.sv
// Load-path extractor: picks the addressed byte/half from a word and extends it.
module memdatos_lane_align
  import memdatos_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = word[8*lane +: 8];
    half_val = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = unsigned_ld ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SZ_HALF: result = unsigned_ld ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/memdatos_sync.sv
// Clocked data memory: strobed stores, extended loads with a 1- or 2-cycle read pipeline.
module memdatos_sync
  import memdatos_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] adress,
  input  logic [DATA_W-1:0] writedata,
  input  logic              ewr,
  input  logic              memread,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              misaligned,
  output logic              out_of_range
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic              misalign_c;
  logic              oor_c;
  logic              err_c;
  logic              wr_en;
  logic              run_reg;
  logic [3:0]        wmask;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] aligned;

  assign word_idx = adress[IDX_W+1:2];
  assign lane     = adress[1:0];
  assign oor_c    = |adress[ADDR_W-1:IDX_W+2];
  assign err_c    = misalign_c | oor_c;
  assign wmask    = lane_mask(size, lane);
  // run_reg holds off stores on the first edge after reset release.
  assign wr_en    = ewr & ~err_c & run_reg;

  always_comb begin
    case (size)
      SZ_BYTE: begin misalign_c = 1'b0;         wdata_rep = {4{writedata[7:0]}};  end
      SZ_HALF: begin misalign_c = lane[0];      wdata_rep = {2{writedata[15:0]}}; end
      SZ_WORD: begin misalign_c = (lane != 2'd0); wdata_rep = writedata;          end
      default: begin misalign_c = 1'b1;         wdata_rep = writedata;            end
    endcase
  end

  // One narrow array per byte lane so each lane has its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en && wmask[gi])
        mem[word_idx] <= wdata_rep[8*gi +: 8];
    end
    assign rd_word[8*gi +: 8] = mem[word_idx];
  end

  memdatos_lane_align u_align (
    .word        (rd_word),
    .lane        (lane),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .result      (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg      <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      run_reg      <= 1'b1;
      misaligned   <= (ewr | memread) & misalign_c;
      out_of_range <= (ewr | memread) & oor_c;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              s1_valid;
    logic              s1_upd;
    logic [DATA_W-1:0] s1_data;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid   <= 1'b0;
        s1_upd     <= 1'b0;
        s1_data    <= '0;
        read_valid <= 1'b0;
        read_data  <= '0;
      end else begin
        s1_valid   <= memread;
        s1_upd     <= memread & ~err_c;
        if (memread && !err_c)
          s1_data  <= aligned;
        read_valid <= s1_valid;
        if (s1_upd)
          read_data <= s1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        read_valid <= 1'b0;
        read_data  <= '0;
      end else begin
        read_valid <= memread;
        if (memread && !err_c)
          read_data <= aligned;
      end
    end
  end

endmodule

// File: tb/tb_memdatos_sync.sv
// Scoreboard bench driving a READ_LAT=1 and a READ_LAT=2 instance with the same stimulus.
module tb_memdatos_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adress;
  logic [31:0] writedata;
  logic        ewr;
  logic        memread;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] rd1, rd2;
  logic        rv1, rv2, mis1, mis2, oor1, oor2;

  always #5 clk = ~clk;

  memdatos_sync #(.READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .adress(adress), .writedata(writedata), .ewr(ewr),
    .memread(memread), .size(size), .unsigned_ld(unsigned_ld), .read_data(rd1),
    .read_valid(rv1), .misaligned(mis1), .out_of_range(oor1));

  memdatos_sync #(.READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .adress(adress), .writedata(writedata), .ewr(ewr),
    .memread(memread), .size(size), .unsigned_ld(unsigned_ld), .read_data(rd2),
    .read_valid(rv2), .misaligned(mis2), .out_of_range(oor2));

  typedef struct { int due; logic [31:0] d; } rd_exp_t;
  typedef struct { int due; logic mis; logic oor; } fl_exp_t;

  rd_exp_t q1[$];
  rd_exp_t q2[$];
  fl_exp_t qf[$];
  rd_exp_t e1, e2;
  fl_exp_t ef;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents read_valid or a flag result is due.
  always @(negedge clk) begin
    if (rv1) begin
      if (q1.size() == 0) check("dut1 unexpected read_valid", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("dut1 read_data", rd1, e1.d);
        check("dut1 latency", cyc, e1.due);
      end
    end else if (q1.size() > 0 && q1[0].due < cyc) begin
      e1 = q1.pop_front();
      check("dut1 missing read_valid", 32'd0, 32'd1);
    end
    if (rv2) begin
      if (q2.size() == 0) check("dut2 unexpected read_valid", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("dut2 read_data", rd2, e2.d);
        check("dut2 latency", cyc, e2.due);
      end
    end else if (q2.size() > 0 && q2[0].due < cyc) begin
      e2 = q2.pop_front();
      check("dut2 missing read_valid", 32'd0, 32'd1);
    end
    if (qf.size() > 0 && qf[0].due <= cyc) begin
      ef = qf.pop_front();
      check("dut1 misaligned", mis1, ef.mis);
      check("dut1 out_of_range", oor1, ef.oor);
      check("dut2 misaligned", mis2, ef.mis);
      check("dut2 out_of_range", oor2, ef.oor);
    end
  end

  // Issue one request; called just after a rising edge, returns just after the sampling edge.
  task automatic op(input logic we, input logic rd, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ed,
                    input logic em, input logic eo);
    ewr = we; memread = rd; size = sz; unsigned_ld = uns; adress = a; writedata = wd;
    qf.push_back('{cyc + 1, em, eo});
    if (rd) begin
      if (!(em | eo)) last_rd = ed;
      q1.push_back('{cyc + 1, last_rd});
      q2.push_back('{cyc + 2, last_rd});
    end
    $display("op we=%0b rd=%0b size=%0b uns=%0b addr=%08h wdata=%08h exp=%08h mis=%0b oor=%0b",
             we, rd, sz, uns, a, wd, last_rd, em, eo);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ewr = 1'b0; memread = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs();
    check("dut1 rst read_data", rd1, 32'd0);
    check("dut1 rst read_valid", rv1, 32'd0);
    check("dut1 rst misaligned", mis1, 32'd0);
    check("dut1 rst out_of_range", oor1, 32'd0);
    check("dut2 rst read_data", rd2, 32'd0);
    check("dut2 rst read_valid", rv2, 32'd0);
    check("dut2 rst misaligned", mis2, 32'd0);
    check("dut2 rst out_of_range", oor2, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ewr = 1'b0; memread = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
    adress = 32'd0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    // word round trip
    op(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    op(0, 1, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    // byte store, sign/zero extension
    op(1, 0, 2'b10, 0, 32'h20, 32'h00000000, 32'h0, 0, 0);
    op(1, 0, 2'b00, 0, 32'h23, 32'h000000F0, 32'h0, 0, 0);
    op(0, 1, 2'b00, 0, 32'h23, 32'h0, 32'hFFFFFFF0, 0, 0);
    op(0, 1, 2'b00, 1, 32'h23, 32'h0, 32'h000000F0, 0, 0);
    op(0, 1, 2'b10, 0, 32'h20, 32'h0, 32'hF0000000, 0, 0);
    // misaligned half store leaves memory untouched
    op(1, 0, 2'b01, 0, 32'h21, 32'h0000AAAA, 32'h0, 1, 0);
    op(0, 1, 2'b10, 0, 32'h20, 32'h0, 32'hF0000000, 0, 0);
    // out-of-range load keeps read_data but still pulses read_valid
    op(0, 1, 2'b10, 0, 32'h200, 32'h0, 32'h0, 0, 1);
    // halfword loads and stores
    op(0, 1, 2'b01, 0, 32'h22, 32'h0, 32'hFFFFF000, 0, 0);
    op(0, 1, 2'b01, 1, 32'h22, 32'h0, 32'h0000F000, 0, 0);
    op(1, 0, 2'b01, 0, 32'h20, 32'h00008001, 32'h0, 0, 0);
    op(0, 1, 2'b01, 0, 32'h20, 32'h0, 32'hFFFF8001, 0, 0);
    op(0, 1, 2'b00, 1, 32'h21, 32'h0, 32'h00000080, 0, 0);
    op(0, 1, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0, 0);
    // simultaneous load and store: read-before-write
    op(1, 0, 2'b10, 0, 32'h30, 32'h11111111, 32'h0, 0, 0);
    op(1, 1, 2'b10, 0, 32'h30, 32'h22222222, 32'h11111111, 0, 0);
    op(0, 1, 2'b10, 0, 32'h30, 32'h0, 32'h22222222, 0, 0);
    // back-to-back loads
    op(1, 0, 2'b10, 0, 32'h0, 32'h00000011, 32'h0, 0, 0);
    op(1, 0, 2'b10, 0, 32'h4, 32'h00000022, 32'h0, 0, 0);
    op(1, 0, 2'b10, 0, 32'h8, 32'h00000033, 32'h0, 0, 0);
    op(0, 1, 2'b10, 0, 32'h0, 32'h0, 32'h00000011, 0, 0);
    op(0, 1, 2'b10, 0, 32'h4, 32'h0, 32'h00000022, 0, 0);
    op(0, 1, 2'b10, 0, 32'h8, 32'h0, 32'h00000033, 0, 0);
    // size=11 is always misaligned
    op(0, 1, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 0);
    idle(3);

    // reset one cycle after a load: only the 1-cycle instance may deliver it
    op(0, 1, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    void'(q2.pop_back());
    ewr = 1'b0; memread = 1'b0;
    @(negedge clk); #1 rst_n = 1'b0;
    last_rd = 32'd0;
    @(negedge clk); #1 check_reset_outputs();
    // store held across reset release must not land
    ewr = 1'b1; size = 2'b10; adress = 32'h10; writedata = 32'h55555555;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    op(0, 1, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    idle(5);

    check("dut1 scoreboard drained", q1.size(), 32'd0);
    check("dut2 scoreboard drained", q2.size(), 32'd0);
    check("flag scoreboard drained", qf.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memdatos_sync.md
# memdatos_sync

Clocked, parametrised data memory for the processor's MEM stage, replacing the combinational data memory. It adds byte/halfword/word stores with lane strobes, sign/zero-extended loads, a configurable read pipeline with a valid pulse, and misalignment/out-of-range error detection. It sits between the ALU result/rt register file path and the write-back mux.

## Interface
- `DATA_W`, 32: word width in bits; must be 32. The byte-lane logic is fixed at 4 lanes.
- `DEPTH`, 128: number of words; power of two.
- `ADDR_W`, 32: byte-address width.
- `READ_LAT`, 1: load latency in cycles; legal values are 1 or 2.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `adress`  in  ADDR_W: byte address.
- `writedata`  in  DATA_W: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ewr`  in  1: store request this cycle.
- `memread`  in  1: load request this cycle.
- `size`  in  2: 00 byte, 01 half, 10 word; 11 is treated as misaligned.
- `unsigned_ld`  in  1: 1 selects zero-extension, 0 selects sign-extension.
- `read_data`  out  DATA_W: aligned, extended load result.
- `read_valid`  out  1: one-cycle pulse when `read_data` is updated.
- `misaligned`  out  1: registered error flag for the accepted request.
- `out_of_range`  out  1: registered error flag for the accepted request.

## Operation
- Word index is `adress[log2(DEPTH)+1:2]`. Byte lane is `adress[1:0]`.
- Alignment rules:
  - Byte: any lane.
  - Half: lane must be 0 or 2.
  - Word: lane must be 0.
  - `size`=11: always misaligned.
- Out-of-range: any bit of `adress[ADDR_W-1:log2(DEPTH)+2]` is nonzero.
- A request with an error is dropped:
  - No array write.
  - For a load, `read_data` keeps its previous value, but `read_valid` still pulses on schedule so the pipeline never hangs.
  - The matching error flag is set in that same cycle.
- Store: on the rising edge with `ewr`=1 and no error, write only the strobed lanes:
  - Byte: lane mask `4'b0001<<lane`.
  - Half: lane mask `4'b0011<<lane`.
  - Word: mask `4'b1111`.
  - Data is replicated onto the lanes.
- Load: sample the word at the edge with `memread`=1. Then extract the addressed byte or half and extend it per `unsigned_ld`.
- `ewr` and `memread` both high at the same address: read-before-write. The load returns the old contents; the store commits at that edge.
- Error flags are registered every cycle from the current request. They are 0 when neither `ewr` nor `memread` is asserted.
- The array is not reset. Its contents after reset are undefined (X in simulation).

## Timing
- Store: one cycle; the data is visible to a load issued on the next cycle.
- Load pipeline:
  - `READ_LAT`=1: the array is read at edge N; `read_data` and `read_valid` are valid after edge N.
  - `READ_LAT`=2: one extra output register stage sits after extract/extend.
- Back-to-back loads are accepted every cycle. `read_valid` tracks each request, with no bubbles.
- Reset (`rst_n`=0, asynchronous) drives:
  - `read_data`=0
  - `read_valid`=0
  - `misaligned`=0
  - `out_of_range`=0
  - All pipeline valid bits = 0.
- A load in flight during reset is discarded and never produces `read_valid`.
- A store on the same edge as reset deassertion is ignored.

## Structure
- Package `memdatos_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - Lane-mask function.
  - Helper that computes the index width, `log2(DEPTH)`.
- Sub-module `memdatos_lane_align`: purely combinational. It takes `{word, lane, size, unsigned_ld}` and produces the extended result. It is used on the load path and is unit-testable on its own.
- Top level holds:
  - The storage array.
  - The strobe write logic.
  - The error checks.
  - The `READ_LAT` pipeline.

## Test plan
- Word round trip: `ewr`=1 at 0x10 with `writedata`=0xDEADBEEF, then `memread`=1 at 0x10. Expect `read_data`=0xDEADBEEF with `read_valid` exactly `READ_LAT` cycles later.
- Byte store with sign- and zero-extension:
  - Setup: word 0x00000000 at 0x20, then `sb` 0x000000F0 to 0x23.
  - `lb` 0x23 → 0xFFFFFFF0.
  - `lbu` 0x23 → 0x000000F0.
  - `lw` 0x20 → 0xF0000000.
- Error handling:
  - `sh` to 0x21: expect `misaligned`=1 and memory unchanged.
  - `lw` to 0x200 with `DEPTH`=128: expect `out_of_range`=1, `read_valid` pulses, `read_data` unchanged.
- Simultaneous load and store to 0x30: old value 0x11111111, new value 0x22222222. The load returns 0x11111111; the next load returns 0x22222222.
- Reset mid-load: assert `rst_n`=0 one cycle after `memread` with `READ_LAT`=2. Expect all outputs 0 and no `read_valid` afterwards.
- Back-to-back: loads to 0x0, 0x4, 0x8 on consecutive cycles. Expect three consecutive `read_valid` pulses with the correct data order.
